// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared types for the ARM ID->EXE pipeline register and its hazard
// scoreboard.
//   EXE_CMD_W  : ALU command width
//   SB_DEST_W  : destination field width held in a scoreboard entry. It must be
//                >= the register-index width; narrower indices are zero-extended.
//   id_ctrl_t  : decoded control bundle carried from ID to EXE
//   sb_entry_t : one in-flight downstream instruction {valid, wb_en, mem_r_en, dest}
// -----------------------------------------------------------------------------
package arm_pkg;

    localparam int unsigned EXE_CMD_W = 4;
    localparam int unsigned SB_DEST_W = 8;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } id_ctrl_t;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_r_en;
        logic [SB_DEST_W-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of destination registers still in flight downstream of ID
// (entry 0 = EXE, entry 1 = MEM, ...) plus the source/destination comparators
// that produce the raw read-after-write hazard for the instruction in ID.
// WB is not tracked: the register file writes before it reads.
//
// Build option: ID_FWD_EN -- when defined, EXE/MEM forwarding exists and only a
// load sitting in entry 0 (load-use) can cause a hazard.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (empties the board)
//   i_new_entry   : entry loaded into slot 0 (mirrors the EXE output register)
//   i_in_valid    : ID holds a real instruction
//   i_src1/i_src2 : source register indices of the ID instruction
//   i_two_src     : i_src2 is a real read
//   o_raw_hazard  : combinational RAW hazard (before flush masking)
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import arm_pkg::*;
#(
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned TRACK_DEPTH = 2   // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  sb_entry_t         i_new_entry,
    input  logic              i_in_valid,
    input  logic [REG_AW-1:0] i_src1,
    input  logic [REG_AW-1:0] i_src2,
    input  logic              i_two_src,
    output logic              o_raw_hazard
);

    sb_entry_t r_sb [TRACK_DEPTH];

    logic [SB_DEST_W-1:0]   w_src1;
    logic [SB_DEST_W-1:0]   w_src2;
    logic [TRACK_DEPTH-1:0] w_hit;

    // Downstream never stalls, so the board advances unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TRACK_DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_sb[0] <= i_new_entry;
            for (int k = 1; k < TRACK_DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    assign w_src1 = SB_DEST_W'(i_src1);
    assign w_src2 = SB_DEST_W'(i_src2);

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < TRACK_DEPTH; k++) begin
`ifdef ID_FWD_EN
            // Everything but a load in EXE is covered by forwarding.
            w_hit[k] = (k == 0) && r_sb[k].valid && r_sb[k].wb_en && r_sb[k].mem_r_en &&
                       ((r_sb[k].dest == w_src1) || (i_two_src && (r_sb[k].dest == w_src2)));
`else
            w_hit[k] = r_sb[k].valid && r_sb[k].wb_en &&
                       ((r_sb[k].dest == w_src1) || (i_two_src && (r_sb[k].dest == w_src2)));
`endif
        end
    end

    assign o_raw_hazard = i_in_valid & (|w_hit);

endmodule

// File: rtl/id_exe_hazard_reg.sv
// -----------------------------------------------------------------------------
// id_exe_hazard_reg
// ID->EXE pipeline register with integrated RAW hazard detection. On a hazard
// the ID instruction is held upstream (hazard freezes PC and IF/ID) and a
// bubble is written into EXE. A taken-branch flush squashes the ID
// instruction and overrides any hazard. stall_count saturates at all-ones.
//
// Build option: ID_FWD_EN -- forwarding present; only load-use stalls.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid, flush          : ID instruction real / squash it
//   *_in                     : decoded controls, operands, immediates, indices
//   src1_in, src2_in, two_src_in : source indices for hazard checking only
//   hazard                   : combinational stall request for IF/ID
//   out_valid, <fields>      : registered EXE-side copy of the ID fields
//   stall_count              : saturating count of hazard cycles
// -----------------------------------------------------------------------------
module id_exe_hazard_reg
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned TRACK_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 flush,
    input  logic                 wb_en_in,
    input  logic                 mem_r_en_in,
    input  logic                 mem_w_en_in,
    input  logic                 b_in,
    input  logic                 s_in,
    input  logic                 imm_in,
    input  logic [EXE_CMD_W-1:0] exe_cmd_in,
    input  logic [DATA_W-1:0]    pc_in,
    input  logic [DATA_W-1:0]    val_rn_in,
    input  logic [DATA_W-1:0]    val_rm_in,
    input  logic [11:0]          shift_operand_in,
    input  logic [23:0]          signed_imm_24_in,
    input  logic [REG_AW-1:0]    dest_in,
    input  logic [REG_AW-1:0]    src1_in,
    input  logic [REG_AW-1:0]    src2_in,
    input  logic                 two_src_in,
    output logic                 hazard,
    output logic                 out_valid,
    output logic                 wb_en,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic                 b,
    output logic                 s,
    output logic                 imm,
    output logic [EXE_CMD_W-1:0] exe_cmd,
    output logic [DATA_W-1:0]    pc,
    output logic [DATA_W-1:0]    val_rn,
    output logic [DATA_W-1:0]    val_rm,
    output logic [11:0]          shift_operand,
    output logic [23:0]          signed_imm_24,
    output logic [REG_AW-1:0]    dest,
    output logic [CNT_W-1:0]     stall_count
);

    logic      w_raw_hazard;
    logic      w_capture;
    id_ctrl_t  w_ctrl_in;
    sb_entry_t w_entry;

    logic                 r_valid;
    id_ctrl_t             r_ctrl;
    logic                 r_imm;
    logic [DATA_W-1:0]    r_pc;
    logic [DATA_W-1:0]    r_val_rn;
    logic [DATA_W-1:0]    r_val_rm;
    logic [11:0]          r_shift_operand;
    logic [23:0]          r_signed_imm_24;
    logic [REG_AW-1:0]    r_dest;
    logic [CNT_W-1:0]     r_stall_count;

    assign hazard    = w_raw_hazard & ~flush;
    // Flush beats hazard beats issue; anything else is a bubble.
    assign w_capture = in_valid & ~flush & ~w_raw_hazard;

    always_comb begin
        w_ctrl_in          = '0;
        w_ctrl_in.wb_en    = wb_en_in;
        w_ctrl_in.mem_r_en = mem_r_en_in;
        w_ctrl_in.mem_w_en = mem_w_en_in;
        w_ctrl_in.b        = b_in;
        w_ctrl_in.s        = s_in;
        w_ctrl_in.exe_cmd  = exe_cmd_in;
    end

    // Slot 0 of the scoreboard tracks exactly what the output register holds.
    always_comb begin
        w_entry          = '0;
        w_entry.valid    = w_capture;
        w_entry.wb_en    = w_capture & wb_en_in;
        w_entry.mem_r_en = w_capture & mem_r_en_in;
        w_entry.dest     = SB_DEST_W'(dest_in);
    end

    hazard_scoreboard #(
        .REG_AW      (REG_AW),
        .TRACK_DEPTH (TRACK_DEPTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_new_entry  (w_entry),
        .i_in_valid   (in_valid),
        .i_src1       (src1_in),
        .i_src2       (src2_in),
        .i_two_src    (two_src_in),
        .o_raw_hazard (w_raw_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid         <= 1'b0;
            r_ctrl          <= '0;
            r_imm           <= 1'b0;
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_dest          <= '0;
            r_stall_count   <= '0;
        end else begin
            r_valid <= w_capture;
            r_ctrl  <= w_capture ? w_ctrl_in : '0;
            // Data fields are don't-care in a bubble, so they simply hold.
            if (w_capture) begin
                r_imm           <= imm_in;
                r_pc            <= pc_in;
                r_val_rn        <= val_rn_in;
                r_val_rm        <= val_rm_in;
                r_shift_operand <= shift_operand_in;
                r_signed_imm_24 <= signed_imm_24_in;
                r_dest          <= dest_in;
            end
            if (hazard && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign out_valid     = r_valid;
    assign wb_en         = r_ctrl.wb_en;
    assign mem_r_en      = r_ctrl.mem_r_en;
    assign mem_w_en      = r_ctrl.mem_w_en;
    assign b             = r_ctrl.b;
    assign s             = r_ctrl.s;
    assign exe_cmd       = r_ctrl.exe_cmd;
    assign imm           = r_imm;
    assign pc            = r_pc;
    assign val_rn        = r_val_rn;
    assign val_rm        = r_val_rm;
    assign shift_operand = r_shift_operand;
    assign signed_imm_24 = r_signed_imm_24;
    assign dest          = r_dest;
    assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
// -----------------------------------------------------------------------------
// tb_id_exe_hazard_reg
// Directed bench for id_exe_hazard_reg (TRACK_DEPTH = 2, CNT_W = 4 so the
// saturation case stays short). Expected stall lengths follow ID_FWD_EN.
// -----------------------------------------------------------------------------
module tb_id_exe_hazard_reg;

    localparam int DW  = 32;
    localparam int RAW = 4;
    localparam int TD  = 2;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

`ifdef ID_FWD_EN
    localparam int ALU_STALLS  = 0;
    localparam int LOAD_STALLS = 1;
`else
    localparam int ALU_STALLS  = TD;
    localparam int LOAD_STALLS = TD;
`endif

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, flush;
    logic            wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]      exe_cmd_in;
    logic [DW-1:0]   pc_in, val_rn_in, val_rm_in;
    logic [11:0]     shift_operand_in;
    logic [23:0]     signed_imm_24_in;
    logic [RAW-1:0]  dest_in, src1_in, src2_in;
    logic            two_src_in;
    logic            hazard, out_valid;
    logic            wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]      exe_cmd;
    logic [DW-1:0]   pc, val_rn, val_rm;
    logic [11:0]     shift_operand;
    logic [23:0]     signed_imm_24;
    logic [RAW-1:0]  dest;
    logic [CW-1:0]   stall_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    id_exe_hazard_reg #(
        .DATA_W      (DW),
        .REG_AW      (RAW),
        .TRACK_DEPTH (TD),
        .CNT_W       (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .flush            (flush),
        .wb_en_in         (wb_en_in),
        .mem_r_en_in      (mem_r_en_in),
        .mem_w_en_in      (mem_w_en_in),
        .b_in             (b_in),
        .s_in             (s_in),
        .imm_in           (imm_in),
        .exe_cmd_in       (exe_cmd_in),
        .pc_in            (pc_in),
        .val_rn_in        (val_rn_in),
        .val_rm_in        (val_rm_in),
        .shift_operand_in (shift_operand_in),
        .signed_imm_24_in (signed_imm_24_in),
        .dest_in          (dest_in),
        .src1_in          (src1_in),
        .src2_in          (src2_in),
        .two_src_in       (two_src_in),
        .hazard           (hazard),
        .out_valid        (out_valid),
        .wb_en            (wb_en),
        .mem_r_en         (mem_r_en),
        .mem_w_en         (mem_w_en),
        .b                (b),
        .s                (s),
        .imm              (imm),
        .exe_cmd          (exe_cmd),
        .pc               (pc),
        .val_rn           (val_rn),
        .val_rm           (val_rm),
        .shift_operand    (shift_operand),
        .signed_imm_24    (signed_imm_24),
        .dest             (dest),
        .stall_count      (stall_count)
    );

    typedef struct {
        logic       v, fl, wb, mr, mw, bb, ss, im;
        logic [3:0] exe, dst, s1, s2;
        logic       two;
        logic       e_hz, e_ov, e_wb, e_mr, e_mw, e_b, e_s;
        logic [3:0] e_exe, e_dst;
        int         e_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic drive(input logic v, input logic wb, input logic mr, input logic [3:0] dst,
                         input logic [3:0] s1, input logic [3:0] s2, input logic two);
        in_valid = v;      flush = L;
        wb_en_in = wb;     mem_r_en_in = mr;  mem_w_en_in = L;
        b_in = L;          s_in = L;          imm_in = L;
        exe_cmd_in = dst;  dest_in = dst;
        src1_in = s1;      src2_in = s2;      two_src_in = two;
        pc_in = 32'h2000 + 32'(dst);
        val_rn_in = 32'h0;  val_rm_in = 32'h0;
        shift_operand_in = 12'h0;  signed_imm_24_in = 24'h0;
    endtask

    task automatic idle(input int n);
        drive(L, L, L, 4'h0, 4'h0, 4'h0, L);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold the consumer already on the inputs until it issues; check the stall
    // length, the bubbles during the stall, the issued instruction and the count.
    task automatic wait_issue(input string name, input int exp_stalls);
        int n;
        n = 0;
        #1;
        while (hazard === 1'b1 && n < 8) begin
            step();
            chk({name, "_bubble"}, 64'(out_valid), 64'(0));
            n++;
            #1;
        end
        chk({name, "_stalls"}, 64'(n), 64'(exp_stalls));
        step();
        chk({name, "_issue_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_issue_dest"}, 64'(dest), 64'(dest_in));
        exp_cnt = sat(exp_cnt + exp_stalls);
        chk({name, "_count"}, 64'(stall_count), 64'(exp_cnt));
    endtask

    initial begin
        //          v  fl wb mr mw b  s  im exe    dst    s1     s2     two  hz ov wb mr mw b  s  exe    dst   cnt
        vecs[0]  = '{H, L, L, L, L, L, L, L, 4'h9, 4'h3, 4'h0, 4'h0, L,   L, H, L, L, L, L, L, 4'h9, 4'h3, 0};
        vecs[1]  = '{H, L, H, L, L, L, L, L, 4'h4, 4'h2, 4'h3, 4'h3, H,   L, H, H, L, L, L, L, 4'h4, 4'h2, 0};
        vecs[2]  = '{H, L, H, H, L, L, L, L, 4'h1, 4'h5, 4'h7, 4'h8, H,   L, H, H, H, L, L, L, 4'h1, 4'h5, 0};
        // src2 matches the in-flight load but is not a real read
        vecs[3]  = '{H, L, H, H, L, L, L, L, 4'hA, 4'h9, 4'h1, 4'h5, L,   L, H, H, H, L, L, L, 4'hA, 4'h9, 0};
        // load-use dependency squashed by a flush in the same cycle
        vecs[4]  = '{H, H, H, L, H, H, H, H, 4'h7, 4'h4, 4'h9, 4'h0, L,   L, L, L, L, L, L, L, 4'h0, 4'h0, 0};
        vecs[5]  = '{L, L, L, L, L, L, L, L, 4'h0, 4'h0, 4'h9, 4'h9, H,   L, L, L, L, L, L, L, 4'h0, 4'h0, 0};
        vecs[6]  = '{H, L, H, L, H, H, H, H, 4'hF, 4'h1, 4'h9, 4'h9, H,   L, H, H, L, H, H, H, 4'hF, 4'h1, 0};
        vecs[7]  = '{H, H, H, H, H, H, H, H, 4'h2, 4'h6, 4'h0, 4'h0, L,   L, L, L, L, L, L, L, 4'h0, 4'h0, 0};
        vecs[8]  = '{H, L, L, L, L, L, L, H, 4'h3, 4'h2, 4'h4, 4'h4, H,   L, H, L, L, L, L, L, 4'h3, 4'h2, 0};
        vecs[9]  = '{H, L, H, H, L, L, L, L, 4'h5, 4'hC, 4'h0, 4'h0, L,   L, H, H, H, L, L, L, 4'h5, 4'hC, 0};
        // two-source load-use: stalls in both builds
        vecs[10] = '{H, L, H, L, L, L, L, L, 4'h6, 4'h7, 4'h3, 4'hC, H,   H, L, L, L, L, L, L, 4'h0, 4'h0, 1};

        rst = H;
        drive(L, L, L, 4'h0, 4'h0, 4'h0, L);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_dest", 64'(dest), 64'(0));
        chk("reset_pc", 64'(pc), 64'(0));
        chk("reset_count", 64'(stall_count), 64'(0));
        chk("reset_hazard", 64'(hazard), 64'(0));
        rst = L;
        step();

        for (int i = 0; i < 11; i++) begin
            in_valid = vecs[i].v;    flush = vecs[i].fl;
            wb_en_in = vecs[i].wb;   mem_r_en_in = vecs[i].mr;  mem_w_en_in = vecs[i].mw;
            b_in = vecs[i].bb;       s_in = vecs[i].ss;         imm_in = vecs[i].im;
            exe_cmd_in = vecs[i].exe;  dest_in = vecs[i].dst;
            src1_in = vecs[i].s1;    src2_in = vecs[i].s2;      two_src_in = vecs[i].two;
            pc_in = 32'h1000 + 32'(i * 4);
            val_rn_in = 32'hA000_0000 + 32'(i);
            val_rm_in = 32'h0B00_0000 + 32'(i);
            shift_operand_in = 12'h100 + 12'(i);
            signed_imm_24_in = 24'h80_0000 + 24'(i);
            #1;
            chk($sformatf("vec%0d_hazard", i), 64'(hazard), 64'(vecs[i].e_hz));
            step();
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_wb_en", i), 64'(wb_en), 64'(vecs[i].e_wb));
            chk($sformatf("vec%0d_mem_r_en", i), 64'(mem_r_en), 64'(vecs[i].e_mr));
            chk($sformatf("vec%0d_mem_w_en", i), 64'(mem_w_en), 64'(vecs[i].e_mw));
            chk($sformatf("vec%0d_b", i), 64'(b), 64'(vecs[i].e_b));
            chk($sformatf("vec%0d_s", i), 64'(s), 64'(vecs[i].e_s));
            chk($sformatf("vec%0d_count", i), 64'(stall_count), 64'(vecs[i].e_cnt));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_dest", i), 64'(dest), 64'(vecs[i].e_dst));
                chk($sformatf("vec%0d_exe_cmd", i), 64'(exe_cmd), 64'(vecs[i].e_exe));
                chk($sformatf("vec%0d_imm", i), 64'(imm), 64'(vecs[i].im));
                chk($sformatf("vec%0d_pc", i), 64'(pc), 64'(32'h1000 + 32'(i * 4)));
                chk($sformatf("vec%0d_val_rn", i), 64'(val_rn), 64'(32'hA000_0000 + 32'(i)));
                chk($sformatf("vec%0d_val_rm", i), 64'(val_rm), 64'(32'h0B00_0000 + 32'(i)));
                chk($sformatf("vec%0d_shift", i), 64'(shift_operand), 64'(12'h100 + 12'(i)));
                chk($sformatf("vec%0d_simm24", i), 64'(signed_imm_24), 64'(24'h80_0000 + 24'(i)));
            end
        end
        exp_cnt = 1;

        // ALU producer directly ahead of its consumer
        idle(3);
        drive(H, H, L, 4'h2, 4'h0, 4'h0, L);
        step();
        drive(H, L, L, 4'h6, 4'h2, 4'h0, L);
        wait_issue("alu_dep", ALU_STALLS);

        // Load-use through src2
        idle(3);
        drive(H, H, H, 4'h5, 4'h0, 4'h0, L);
        step();
        drive(H, H, L, 4'h7, 4'h0, 4'h5, H);
        wait_issue("load_use", LOAD_STALLS);

        // Drive the counter well past all-ones
        for (int i = 0; i < 20; i++) begin
            drive(H, H, H, 4'h5, 4'h0, 4'h0, L);
            step();
            drive(H, L, L, 4'h8, 4'h5, 4'h0, L);
            wait_issue($sformatf("sat%0d", i), LOAD_STALLS);
        end
        chk("count_saturated", 64'(stall_count), 64'(CNT_MAX));

        // Asynchronous reset in the middle of a stall
        idle(3);
        drive(H, H, H, 4'h5, 4'h0, 4'h0, L);
        step();
        chk("pre_reset_valid", 64'(out_valid), 64'(1));
        drive(H, L, L, 4'h9, 4'h5, 4'h0, L);
        #1;
        chk("pre_reset_hazard", 64'(hazard), 64'(1));
        #1;
        rst = H;
        #1;
        chk("mid_reset_out_valid", 64'(out_valid), 64'(0));
        chk("mid_reset_wb_en", 64'(wb_en), 64'(0));
        chk("mid_reset_mem_r_en", 64'(mem_r_en), 64'(0));
        chk("mid_reset_dest", 64'(dest), 64'(0));
        chk("mid_reset_pc", 64'(pc), 64'(0));
        chk("mid_reset_count", 64'(stall_count), 64'(0));
        chk("mid_reset_hazard", 64'(hazard), 64'(0));
        #2;
        rst = L;
        #1;
        chk("post_reset_hazard", 64'(hazard), 64'(0));
        step();
        chk("post_reset_issue", 64'(out_valid), 64'(1));
        chk("post_reset_dest", 64'(dest), 64'(9));
        chk("post_reset_count", 64'(stall_count), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_hazard_reg.md
# id_exe_hazard_reg

Parametrised ID→EXE pipeline register with integrated hazard detection for the ARM pipeline. Captures the decoded control and operand fields from the ID stage each cycle. Keeps a scoreboard of destination registers still in flight downstream and raises `hazard` to freeze IF/ID while inserting a bubble into EXE. Supports a branch `flush` and a saturating stall counter.

## Interface
- `DATA_W`, 32, operand/PC width
- `REG_AW`, 4, register-index width
- `TRACK_DEPTH`, 2, downstream stages tracked (entry 0 = EXE, entry 1 = MEM, …); legal range 1..4
- `CNT_W`, 16, stall-counter width

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `in_valid` in 1 — ID holds a real instruction
- `flush` in 1 — branch taken in EXE; squash the ID instruction
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `b_in`, `s_in`, `imm_in` in 1 each — decoded controls
- `exe_cmd_in` in 4 — ALU command
- `pc_in`, `val_rn_in`, `val_rm_in` in DATA_W — PC+4 and register operands
- `shift_operand_in` in 12; `signed_imm_24_in` in 24 — immediate fields
- `dest_in`, `src1_in`, `src2_in` in REG_AW — destination and source indices
- `two_src_in` in 1 — `src2_in` is a real read
- `hazard` out 1 — combinational; freeze PC and IF/ID this cycle
- `out_valid` out 1 — EXE-side instruction is real
- All `*_in` fields except `src1_in`, `src2_in`, `two_src_in` are also outputs without the `_in` suffix, registered, with the same widths
- `stall_count` out CNT_W — saturating count of hazard cycles

## Operation
- **Scoreboard.** `TRACK_DEPTH` entries of {valid, wb_en, mem_r_en, dest}.
  - Entry 0 mirrors the output register.
  - Every cycle, entry k+1 ← entry k and the oldest entry is discarded. Downstream never stalls.
- **Raw hazard.** `in_valid` and some entry e satisfies both conditions below:
  - e.valid & e.wb_en (subject to the forwarding rule in Configuration).
  - e.dest == src1_in, or (two_src_in and e.dest == src2_in).
- `hazard` = raw hazard & ~flush.
- **Register update, in priority order:**
  - rst: all outputs 0, scoreboard invalid, `stall_count` = 0.
  - flush: bubble. `out_valid` = 0 and every control bit (`wb_en`, `mem_r_en`, `mem_w_en`, `b`, `s`) = 0. Data fields may hold any value.
  - hazard: bubble, same as flush.
  - in_valid: capture all inputs; `out_valid` = 1.
  - else: bubble.
- `stall_count` increments on each cycle with `hazard` = 1 and saturates at all-ones.
- Register-file write-before-read in WB is relied upon. WB is therefore not tracked.

## Timing
- Output latency: one cycle from ID inputs to registered outputs.
- `hazard` is valid in the same cycle as the inputs; upstream samples it before the edge.
- Without forwarding, a consumer directly behind its producer stalls exactly `TRACK_DEPTH` cycles.
- With forwarding, a load-use pair stalls exactly 1 cycle; all other dependencies stall 0 cycles.
- flush and hazard in the same cycle: flush wins. `hazard` = 0 and no stall is counted.
- Asynchronous reset mid-stall: outputs clear immediately. The next cycle's `hazard` depends only on new inputs, since the scoreboard is empty.

## Configuration
- `ID_FWD_EN` defined: only entry 0 with mem_r_en = 1 can cause a hazard (load-use). EXE/MEM forwarding resolves all other dependencies.
- `ID_FWD_EN` undefined: any valid wb_en entry in the scoreboard whose dest matches causes a hazard.

## Structure
- Package `arm_pkg`:
  - `EXE_CMD_W` = 4.
  - Typedef `id_ctrl_t` {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}.
  - Typedef `sb_entry_t`.
- Sub-module `hazard_scoreboard`: entry shift register plus comparators, producing raw hazard. It is instantiated once.

## Test plan
- Reset release, then `in_valid` = 1, `dest_in` = 3, `exe_cmd_in` = 4'h9 → next cycle `out_valid` = 1, `dest` = 3, `exe_cmd` = 4'h9, `hazard` = 0 throughout.
- Forwarding off, TRACK_DEPTH = 2: ADD R2 (`wb_en` = 1), then SUB with `src1_in` = 2 → `hazard` high for 2 cycles, two bubbles (`out_valid` = 0), SUB issues on the 3rd cycle, `stall_count` = 2.
- `ID_FWD_EN` defined: LDR R5 (`mem_r_en` = 1), then ADD with `src2_in` = 5, `two_src_in` = 1 → exactly 1 stall. A non-load producer with the same dependency → 0 stalls.
- `two_src_in` = 0 with `src2_in` matching an in-flight dest and `src1_in` not matching → `hazard` = 0.
- A dependency that raises hazard, with `flush` = 1 in the same cycle → `hazard` = 0, bubble, `stall_count` unchanged.
- Force 2^CNT_W + 3 hazard cycles → `stall_count` holds at all-ones. Assert `rst` mid-stall → all outputs 0 immediately.
